// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Column drive is active-low one-hot, matching the seven-segment scan path.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_PRESSED,
    ST_DEB_REL
  } kp_state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } scan_cls_t;

  localparam logic [NUM_COLS-1:0] COL_PATTERN [0:NUM_COLS-1] =
    '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Number of asserted rows, saturated at 2 (anything above one key is MULTI).
  function automatic logic [1:0] low_count(input logic [NUM_ROWS-1:0] lows);
    int n;
    n = 0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      n = n + int'(lows[i]);
    end
    return (n >= 2) ? 2'd2 : 2'(n);
  endfunction

  function automatic logic [1:0] low_index(input logic [NUM_ROWS-1:0] lows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (lows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad row inputs.
// Resets to all-ones so an idle (pulled-up) keypad is seen during and after reset.
module sync_2ff #(
  parameter int               W         = 4,
  parameter logic [W-1:0]     RESET_VAL = '1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: column drive, per-scan classification, debounce FSM.
// Optional auto-repeat while a key is held is built when KEYPAD_REPEAT_EN is defined.
//
// state        | meaning
// ST_IDLE      | no key accepted, waiting for a scan with exactly one key
// ST_DEB_PRESS | same single key seen r_deb_cnt consecutive scans
// ST_PRESSED   | key accepted, key_held high, extra keys ignored
// ST_DEB_REL   | empty scans counted in r_deb_cnt before release is accepted
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_DELAY   = 250,
  parameter int REPEAT_RATE    = 50
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_ROWS-1:0] i_row_n,
  output logic [NUM_COLS-1:0] o_col_n,
  output logic [3:0]          o_key_code,
  output logic                o_key_valid,
  output logic                o_key_held
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("keypad_scan: invalid parameter set");
  end

  logic [NUM_ROWS-1:0] w_row_sync;
  logic [NUM_ROWS-1:0] w_lows;
  logic                w_dwell_end;
  logic                w_scan_close;
  logic [1:0]          w_col_cnt;
  logic [2:0]          w_sum;
  logic [3:0]          w_sample_code;
  logic [3:0]          w_code;
  scan_cls_t           w_cls;
  logic [DW-1:0]       w_deb_next;

  logic [PW-1:0]       r_presc;
  logic [1:0]          r_col_idx;
  logic [1:0]          r_acc_cnt;
  logic [3:0]          r_acc_code;
  kp_state_t           r_state;
  logic [3:0]          r_cand;
  logic [DW-1:0]       r_deb_cnt;
  logic [3:0]          r_key_code;
  logic                r_key_valid;
  logic                r_key_held;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);
  logic [RW-1:0]       r_rpt_cnt;
`endif

  sync_2ff #(
    .W         (NUM_ROWS),
    .RESET_VAL ({NUM_ROWS{1'b1}})
  ) u_row_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_row_n),
    .o_q     (w_row_sync)
  );

  assign w_dwell_end  = (r_presc == PW'(SCAN_DIV - 1));
  assign w_scan_close = w_dwell_end && (r_col_idx == 2'd3);
  assign w_deb_next   = r_deb_cnt + DW'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_presc   <= '0;
      r_col_idx <= 2'd0;
    end else if (w_dwell_end) begin
      r_presc   <= '0;
      r_col_idx <= r_col_idx + 2'd1;
    end else begin
      r_presc   <= r_presc + PW'(1);
    end
  end

  // The closing column is folded in combinationally so the FSM sees the whole scan.
  always_comb begin
    w_lows        = ~w_row_sync;
    w_col_cnt     = low_count(w_lows);
    w_sum         = {1'b0, r_acc_cnt} + {1'b0, w_col_cnt};
    w_sample_code = {r_col_idx, low_index(w_lows)};
    w_code        = (w_col_cnt == 2'd1) ? w_sample_code : r_acc_code;
    w_cls         = CLS_NONE;
    if (w_sum >= 3'd2) begin
      w_cls = CLS_MULTI;
    end else if (w_sum == 3'd1) begin
      w_cls = CLS_SINGLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_dwell_end) begin
      if (r_col_idx == 2'd3) begin
        r_acc_cnt  <= 2'd0;
        r_acc_code <= 4'd0;
      end else begin
        r_acc_cnt <= (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        if (w_col_cnt == 2'd1) r_acc_code <= w_sample_code;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cand      <= 4'd0;
      r_deb_cnt   <= '0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rpt_cnt   <= '0;
`endif
    end else begin
      r_key_valid <= 1'b0;
      if (w_scan_close) begin
        case (r_state)
          ST_IDLE: begin
            if (w_cls == CLS_SINGLE) begin
              r_state   <= ST_DEB_PRESS;
              r_cand    <= w_code;
              r_deb_cnt <= DW'(1);
            end
          end
          ST_DEB_PRESS: begin
            if (w_cls != CLS_SINGLE) begin
              r_state   <= ST_IDLE;
              r_deb_cnt <= '0;
            end else if (w_code != r_cand) begin
              r_cand    <= w_code;
              r_deb_cnt <= DW'(1);
            end else if (w_deb_next == DW'(DEBOUNCE_SCANS)) begin
              r_state     <= ST_PRESSED;
              r_key_code  <= r_cand;
              r_key_valid <= 1'b1;
              r_key_held  <= 1'b1;
              r_deb_cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
              r_rpt_cnt   <= RW'(REPEAT_DELAY);
`endif
            end else begin
              r_deb_cnt <= w_deb_next;
            end
          end
          ST_PRESSED: begin
            if (w_cls == CLS_NONE) begin
              r_state   <= ST_DEB_REL;
              r_deb_cnt <= DW'(1);
            end
`ifdef KEYPAD_REPEAT_EN
            else if (r_rpt_cnt < RW'(2)) begin
              r_key_valid <= 1'b1;
              r_rpt_cnt   <= RW'(REPEAT_RATE);
            end else begin
              r_rpt_cnt <= r_rpt_cnt - RW'(1);
            end
`endif
          end
          ST_DEB_REL: begin
            // A bounce back to PRESSED keeps the repeat count where it was.
            if (w_cls != CLS_NONE) begin
              r_state   <= ST_PRESSED;
              r_deb_cnt <= '0;
            end else if (w_deb_next == DW'(DEBOUNCE_SCANS)) begin
              r_state    <= ST_IDLE;
              r_key_held <= 1'b0;
              r_deb_cnt  <= '0;
`ifdef KEYPAD_REPEAT_EN
              r_rpt_cnt  <= '0;
`endif
            end else begin
              r_deb_cnt <= w_deb_next;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_col_n     = COL_PATTERN[r_col_idx];
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan with a behavioural 4x4 keypad matrix.
// Define KEYPAD_REPEAT_EN for both bench and RTL to exercise auto-repeat.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0000;

  typedef struct {
    logic [3:0] code;
    int         scan;
  } exp_t;

  exp_t exp_q [$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   scan_no = 0;

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
    .REPEAT_DELAY   (4),
    .REPEAT_RATE    (2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_row_n     (row_n),
    .o_col_n     (col_n),
    .o_key_code  (key_code),
    .o_key_valid (key_valid),
    .o_key_held  (key_held)
  );

  // keys[c*4+r]: row r reads low while column c (col_n bit 3-c) is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4+r] && !col_n[3-c]) row_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_checks++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_scans(input int n);
    int t;
    int g;
    t = scan_no + n;
    g = 0;
    while (scan_no < t && g < n * 20 + 40) begin
      @(negedge clk);
      g++;
    end
    if (scan_no < t) fail_now("scan_timeout", scan_no, t);
  endtask

  task automatic expect_pulse(input logic [3:0] code, input int scan);
    exp_q.push_back(exp_t'{code, scan});
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_col_n"}, col_n, 4'b0111);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_held"}, key_held, 0);
    check({tag, "_code"}, key_code, 0);
    rst_n = 1'b1;
  endtask

  // Monitor: scan counter plus scoreboard pop on every key_valid.
  logic [3:0] prev_col = 4'b0111;
  logic [3:0] prev_code = 4'b0000;
  logic       prev_valid = 1'b0;
  logic       prev_rst = 1'b0;

  always @(posedge clk) begin
    #1;
    if (prev_col == 4'b1110 && col_n == 4'b0111) scan_no++;
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_pulse_code", int'(key_code), -1);
      end else begin
        m_e = exp_q.pop_front();
        check("pulse_code", key_code, m_e.code);
        check("pulse_scan", scan_no, m_e.scan);
      end
      if (prev_valid) fail_now("valid_back_to_back", 1, 0);
    end else if (rst_n && prev_rst && key_code !== prev_code) begin
      fail_now("code_change_no_valid", int'(key_code), int'(prev_code));
    end
    prev_col   = col_n;
    prev_code  = key_code;
    prev_valid = (key_valid === 1'b1);
    prev_rst   = rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    logic [3:0] pat [4];
    pat = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // 1: reset values and column rotation
    repeat (2) @(negedge clk);
    check("rst_col_n", col_n, 4'b0111);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_code", key_code, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("col_seq", col_n, pat[i/4]);
      @(negedge clk);
    end

    // 2: clean press of row1/col2, then release
    wait_scans(1);
    b = scan_no;
    keys[2*4+1] = 1'b1;
    expect_pulse(4'b1001, b + 3);
    wait_scans(6);
    check("t2_held", key_held, 1);
    check("t2_code", key_code, 4'b1001);
    keys = 16'h0;
    wait_scans(2);
    check("t2_held_rel2", key_held, 1);
    wait_scans(1);
    check("t2_held_rel3", key_held, 0);
    check("t2_pending", exp_q.size(), 0);

    // 3: bounce on row3/col0
    b = scan_no;
    keys[0*4+3] = 1'b1;
    wait_scans(2);
    keys = 16'h0;
    wait_scans(1);
    keys[0*4+3] = 1'b1;
    expect_pulse(4'b0011, b + 6);
    wait_scans(3);
    check("t3_held", key_held, 1);
    check("t3_pending", exp_q.size(), 0);
    keys = 16'h0;
    wait_scans(4);
    check("t3_held_rel", key_held, 0);

    // 4: two keys in one column, then a second key while pressed
    keys[3*4+0] = 1'b1;
    keys[3*4+1] = 1'b1;
    wait_scans(5);
    check("t4_multi_held", key_held, 0);
    keys = 16'h0;
    wait_scans(2);
    b = scan_no;
    keys[1*4+2] = 1'b1;
    expect_pulse(4'b0110, b + 3);
    wait_scans(3);
    keys[1*4+3] = 1'b1;
    keys[0*4+0] = 1'b1;
    wait_scans(2);
    check("t4_code_kept", key_code, 4'b0110);
    check("t4_held", key_held, 1);
    keys = 16'h0;
    wait_scans(4);
    check("t4_held_rel", key_held, 0);
    check("t4_pending", exp_q.size(), 0);

    // 5: reset mid-DEB_PRESS and mid-PRESSED with key still held
    keys[2*4+1] = 1'b1;
    wait_scans(2);
    reset_pulse("t5a");
    @(negedge clk);
    b = scan_no;
    expect_pulse(4'b1001, b + 3);
    wait_scans(4);
    check("t5_held", key_held, 1);
    check("t5_code", key_code, 4'b1001);
    reset_pulse("t5b");
    @(negedge clk);
    b = scan_no;
    expect_pulse(4'b1001, b + 3);
    wait_scans(3);
    check("t5_held_again", key_held, 1);
    keys = 16'h0;
    wait_scans(4);
    check("t5_pending", exp_q.size(), 0);

    // 6: long hold on row2/col3
    b = scan_no;
    keys[3*4+2] = 1'b1;
    expect_pulse(4'b1110, b + 3);
`ifdef KEYPAD_REPEAT_EN
    expect_pulse(4'b1110, b + 7);
    expect_pulse(4'b1110, b + 9);
    expect_pulse(4'b1110, b + 11);
    expect_pulse(4'b1110, b + 13);
`endif
    wait_scans(13);
    check("t6_held", key_held, 1);
    keys = 16'h0;
    wait_scans(4);
    check("t6_held_rel", key_held, 0);
    check("t6_pending", exp_q.size(), 0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
